// File: rtl/mioc_pkg.sv
// mioc_pkg: shared types and constants for the mioc open-drain line logic.
//   mioc_filt_state_t    : qualification FSM states of the line filter
//   MIOC_SYNC_STAGES_DEF : default synchroniser depth
//   MIOC_FILT_LEN_DEF    : default qualification length in sampled cycles
//   MIOC_OD_IDLE         : level of the pulled-up, undriven wired-NOR net
package mioc_pkg;

   typedef enum logic [1:0] {
      STABLE_HI = 2'd0,
      QUAL_LO   = 2'd1,
      STABLE_LO = 2'd2,
      QUAL_HI   = 2'd3
   } mioc_filt_state_t;

   localparam int   MIOC_SYNC_STAGES_DEF = 2;
   localparam int   MIOC_FILT_LEN_DEF    = 4;
   localparam logic MIOC_OD_IDLE         = 1'b1;

endpackage

// File: rtl/mioc_sync_chain.sv
// mioc_sync_chain: STAGES-deep flop chain bringing an asynchronous level into
// the clk domain.
//   clk : block clock
//   rst : asynchronous active-high reset, loads RST_VAL into every flop
//   d   : asynchronous input level
//   q   : synchronised level (last flop), STAGES rising edges behind d
module mioc_sync_chain
   import mioc_pkg::*;
#(
   parameter int   STAGES  = MIOC_SYNC_STAGES_DEF,
   parameter logic RST_VAL = MIOC_OD_IDLE
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= {STAGES{RST_VAL}};
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/mioc_od_line_filter.sv
// mioc_od_line_filter: turns the open-drain wired-NOR net into a clean,
// debounced, clock-synchronous level with edge strobes and a glitch counter.
//   clk        : block clock
//   rst        : asynchronous active-high reset
//   z_in       : raw wired-NOR net (asynchronous, pulled up)
//   glitch_clr : synchronous clear of glitch_cnt (beats a same-cycle reject)
//   z_sync     : synchroniser output
//   z_filt     : qualified line level, idle high
//   fall_pulse : one-cycle strobe when z_filt goes 1->0
//   rise_pulse : one-cycle strobe when z_filt goes 0->1
//   glitch_cnt : saturating count of rejected transitions
module mioc_od_line_filter
   import mioc_pkg::*;
#(
   parameter int SYNC_STAGES = MIOC_SYNC_STAGES_DEF,
   parameter int FILT_LEN    = MIOC_FILT_LEN_DEF,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             z_in,
   input  logic             glitch_clr,
   output logic             z_sync,
   output logic             z_filt,
   output logic             fall_pulse,
   output logic             rise_pulse,
   output logic [CNT_W-1:0] glitch_cnt
);

   // qual_cnt holds the number of sampled cycles the new level has held so
   // far; the cycle that would bring it to FILT_LEN is the accepting one.
   localparam logic [3:0] QUAL_LAST = 4'(FILT_LEN - 1);

   mioc_filt_state_t state, state_nx;
   logic [3:0]       qual_cnt, qual_nx;
   logic             filt_nx, fall_nx, rise_nx, reject;

   mioc_sync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (MIOC_OD_IDLE)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (z_in),
      .q   (z_sync)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= STABLE_HI;
         qual_cnt   <= '0;
         z_filt     <= MIOC_OD_IDLE;
         fall_pulse <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         state      <= state_nx;
         qual_cnt   <= qual_nx;
         z_filt     <= filt_nx;
         fall_pulse <= fall_nx;
         rise_pulse <= rise_nx;
      end
   end

   always_comb begin
      state_nx = state;
      qual_nx  = qual_cnt;
      filt_nx  = z_filt;
      fall_nx  = 1'b0;
      rise_nx  = 1'b0;
      reject   = 1'b0;
      case (state)
         STABLE_HI: begin
            if (!z_sync) begin
               state_nx = QUAL_LO;
               qual_nx  = 4'd1;
            end
         end
         QUAL_LO: begin
            if (!z_sync) begin
               if (qual_cnt == QUAL_LAST) begin
                  state_nx = STABLE_LO;
                  qual_nx  = '0;
                  filt_nx  = 1'b0;
                  fall_nx  = 1'b1;
               end else begin
                  qual_nx = qual_cnt + 4'd1;
               end
            end else begin
               state_nx = STABLE_HI;
               qual_nx  = '0;
               reject   = 1'b1;
            end
         end
         STABLE_LO: begin
            if (z_sync) begin
               state_nx = QUAL_HI;
               qual_nx  = 4'd1;
            end
         end
         QUAL_HI: begin
            if (z_sync) begin
               if (qual_cnt == QUAL_LAST) begin
                  state_nx = STABLE_HI;
                  qual_nx  = '0;
                  filt_nx  = 1'b1;
                  rise_nx  = 1'b1;
               end else begin
                  qual_nx = qual_cnt + 4'd1;
               end
            end else begin
               state_nx = STABLE_LO;
               qual_nx  = '0;
               reject   = 1'b1;
            end
         end
         default: begin
            state_nx = STABLE_HI;
            qual_nx  = '0;
            filt_nx  = MIOC_OD_IDLE;
         end
      endcase
   end

   // Clear has priority over a same-cycle rejection; the count sticks at max.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              glitch_cnt <= '0;
      else if (glitch_clr)                  glitch_cnt <= '0;
      else if (reject && glitch_cnt != '1)  glitch_cnt <= glitch_cnt + 1'b1;
   end

endmodule

// File: tb/tb_mioc_od_line_filter.sv
module tb_mioc_od_line_filter;

   localparam int SYNC = 2;
   localparam int FILT = 4;
   localparam int LAT  = SYNC + FILT;
   localparam int CW   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          drv_en, drv_val;
   logic          glitch_clr;
   wire           z_net;
   logic          z_sync, z_filt, fall_pulse, rise_pulse;
   logic [CW-1:0] glitch_cnt;

   // open-drain net model: undriven reads as the pull-up level
   pullup (z_net);
   assign z_net = drv_en ? drv_val : 1'bz;

   mioc_od_line_filter #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .z_in       (z_net),
      .glitch_clr (glitch_clr),
      .z_sync     (z_sync),
      .z_filt     (z_filt),
      .fall_pulse (fall_pulse),
      .rise_pulse (rise_pulse),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   // scoreboard of expected edge strobes: kind 1 = fall, 0 = rise
   typedef struct {
      logic kind;
      int   at;
   } ev_t;
   ev_t sb[$];

   task automatic push(input logic kind, input int at);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && (fall_pulse || rise_pulse)) begin
         chk("pulse_both", {31'd0, fall_pulse & rise_pulse}, 32'd0);
         if (sb.size() == 0) begin
            chk("pulse_unexpected", {30'd0, fall_pulse, rise_pulse}, 32'd0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            chk("pulse_kind", {31'd0, fall_pulse}, {31'd0, e.kind});
            chk("pulse_cyc", cyc, e.at);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // low pulse lasting len cycles on z_in (and so on z_sync)
   task automatic low_pulse(input int len);
      int k;
      k = cyc;
      drv_val = 1'b0;
      if (len >= FILT) begin
         push(1'b1, k + LAT);
         push(1'b0, k + len + LAT);
      end
      tick(len);
      drv_val = 1'b1;
   endtask

   initial begin
      int k;
      rst = 1'b1; drv_en = 1'b1; drv_val = 1'b1; glitch_clr = 1'b0;
      tick(3);
      rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_filt", {31'd0, z_filt}, 32'd1);
         chk("idle_sync", {31'd0, z_sync}, 32'd1);
         chk("idle_gcnt", {24'd0, glitch_cnt}, 32'd0);
      end

      // clean fall and rise
      k = cyc;
      drv_val = 1'b0;
      push(1'b1, k + LAT);
      tick(1);
      chk("sync_lag", {31'd0, z_sync}, 32'd1);
      tick(1);
      chk("sync_low", {31'd0, z_sync}, 32'd0);
      tick(3);
      chk("filt_before_fall", {31'd0, z_filt}, 32'd1);
      tick(1);
      chk("filt_after_fall", {31'd0, z_filt}, 32'd0);
      tick(10);
      k = cyc;
      drv_val = 1'b1;
      push(1'b0, k + LAT);
      tick(5);
      chk("filt_before_rise", {31'd0, z_filt}, 32'd0);
      tick(1);
      chk("filt_after_rise", {31'd0, z_filt}, 32'd1);
      tick(4);
      chk("sb_empty_clean", sb.size(), 32'd0);

      // FILT_LEN-1 rejected, FILT_LEN accepted
      low_pulse(FILT - 1);
      tick(8);
      chk("short_gcnt", {24'd0, glitch_cnt}, 32'd1);
      chk("short_filt", {31'd0, z_filt}, 32'd1);
      low_pulse(FILT);
      tick(12);
      chk("long_gcnt", {24'd0, glitch_cnt}, 32'd1);
      chk("sb_empty_pulse", sb.size(), 32'd0);

      // saturation
      glitch_clr = 1'b1;
      tick(1);
      glitch_clr = 1'b0;
      chk("clr_gcnt", {24'd0, glitch_cnt}, 32'd0);
      for (int i = 0; i < 100; i++) begin low_pulse(2); tick(2); end
      tick(6);
      chk("gcnt_100", {24'd0, glitch_cnt}, 32'd100);
      for (int i = 0; i < 200; i++) begin low_pulse(2); tick(2); end
      tick(6);
      chk("gcnt_sat", {24'd0, glitch_cnt}, 32'd255);
      low_pulse(2);
      tick(6);
      chk("gcnt_sat_hold", {24'd0, glitch_cnt}, 32'd255);
      chk("sat_filt", {31'd0, z_filt}, 32'd1);

      // clear beats a same-cycle rejection (reject lands on edge k+5)
      glitch_clr = 1'b1;
      tick(1);
      glitch_clr = 1'b0;
      low_pulse(2);
      tick(6);
      chk("gcnt_one", {24'd0, glitch_cnt}, 32'd1);
      low_pulse(2);
      tick(2);
      glitch_clr = 1'b1;
      tick(1);
      glitch_clr = 1'b0;
      chk("clr_vs_reject", {24'd0, glitch_cnt}, 32'd0);
      tick(3);
      chk("clr_vs_reject_hold", {24'd0, glitch_cnt}, 32'd0);

      // async reset mid QUAL_LO with qual_cnt = 2
      low_pulse(2);
      tick(6);
      chk("pre_rst_gcnt", {24'd0, glitch_cnt}, 32'd1);
      drv_val = 1'b0;
      tick(4);
      #2 rst = 1'b1;
      #1;
      chk("rst_sync", {31'd0, z_sync}, 32'd1);
      chk("rst_filt", {31'd0, z_filt}, 32'd1);
      chk("rst_fall", {31'd0, fall_pulse}, 32'd0);
      chk("rst_rise", {31'd0, rise_pulse}, 32'd0);
      chk("rst_gcnt", {24'd0, glitch_cnt}, 32'd0);
      tick(2);
      rst = 1'b0;
      k = cyc;
      push(1'b1, k + LAT);
      tick(10);
      chk("post_rst_filt", {31'd0, z_filt}, 32'd0);
      chk("post_rst_gcnt", {24'd0, glitch_cnt}, 32'd0);
      k = cyc;
      drv_val = 1'b1;
      push(1'b0, k + LAT);
      tick(10);
      chk("sb_empty_rst", sb.size(), 32'd0);

      // undriven net reads as idle high
      drv_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("z_sync_hiz", {31'd0, z_sync}, 32'd1);
         chk("z_filt_hiz", {31'd0, z_filt}, 32'd1);
      end
      chk("gcnt_hiz", {24'd0, glitch_cnt}, 32'd0);
      chk("sb_empty_end", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
